hour_chime_ctrl: RTL

//   Parametrised hourly chime sequencer for the digital clock.
//   On each hour rollover, rings N discrete strikes (N = hour, 12h or 24h style).

---
 rtl/hour_chime_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hour_chime_ctrl.sv
// Hourly chime sequencer: strikes the hour count as c500-gated bursts on bell.
// Define HALF_HOUR_CHIME_EN to also ring a single strike at mm:ss = 30:00.
module hour_chime_ctrl #(
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 1,
  parameter int MODE12    = 1,
  parameter int CNT_W     = 4
) (
  input  logic        CP,
  input  logic        CR,
  input  logic        tick,
  input  logic        toll,
  input  logic        c500,
  input  logic [23:0] hms,
  output logic        bell,
  output logic        busy,
  output logic [4:0]  strikes_left
);

  typedef enum logic [1:0] {IDLE, RING, GAP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [4:0]         strikes_q, strikes_d;
  logic [15:0]        prev_ms_q;

  logic [3:0]         hh_tens, hh_ones;
  logic [4:0]         hh_bin, hour_n, start_n;
  logic               hh_valid, hour_trig, start;

  // Hour decode: BCD hh to strike count, zero for anything not a real hour
  always_comb begin
    hh_tens  = hms[23:20];
    hh_ones  = hms[19:16];
    hh_bin   = {1'b0, hh_ones} + ((hh_tens == 4'd1) ? 5'd10 :
                                  (hh_tens == 4'd2) ? 5'd20 : 5'd0);
    hh_valid = (hh_tens <= 4'd2) && (hh_ones <= 4'd9) && (hh_bin <= 5'd23);
    hour_n   = '0;
    if (hh_valid) begin
      if (MODE12 != 0) begin
        if (hh_bin == 5'd0)       hour_n = 5'd12;
        else if (hh_bin > 5'd12)  hour_n = hh_bin - 5'd12;
        else                      hour_n = hh_bin;
      end else begin
        hour_n = (hh_bin == 5'd0) ? 5'd24 : hh_bin;
      end
    end
  end

  always_comb begin
    hour_trig = toll && (hms[15:0] == 16'h0000) && (prev_ms_q != 16'h0000);
    start     = hour_trig && (hour_n != 5'd0);
    start_n   = hour_n;
`ifdef HALF_HOUR_CHIME_EN
    if (toll && (hms[15:0] == 16'h3000) && (prev_ms_q != 16'h3000)) begin
      start   = 1'b1;
      start_n = 5'd1;
    end
`endif
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      strikes_q <= '0;
      prev_ms_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      strikes_q <= strikes_d;
      prev_ms_q <= hms[15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    strikes_d = strikes_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RING;
          strikes_d = start_n;
          phase_d   = '0;
        end
      end
      RING: begin
        // toll checked first so an abort beats a coincident tick
        if (!toll) begin
          state_d   = IDLE;
          strikes_d = '0;
          phase_d   = '0;
        end else if (tick) begin
          if (phase_q == CNT_W'(ON_TICKS - 1)) begin
            phase_d   = '0;
            strikes_d = strikes_q - 5'd1;
            state_d   = (strikes_q == 5'd1) ? IDLE : GAP;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (!toll) begin
          state_d   = IDLE;
          strikes_d = '0;
          phase_d   = '0;
        end else if (tick) begin
          if (phase_q == CNT_W'(OFF_TICKS - 1)) begin
            phase_d = '0;
            state_d = RING;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        strikes_d = '0;
        phase_d   = '0;
      end
    endcase
  end

  always_comb begin
    bell         = (state_q == RING) && c500;
    busy         = (state_q != IDLE);
    strikes_left = (state_q == IDLE) ? 5'd0 : strikes_q;
  end

endmodule
